vga_fb_reader: RTL and testbench

VGA_FB_READER -- requirements
Module: vga_fb_reader

---
 rtl/vga_fb_reader_pkg.sv | 14 +
 rtl/vga_fb_reader_sync_fifo.sv | 56 +++++
 rtl/vga_fb_reader.sv | 125 ++++++++++++
 tb/tb_vga_fb_reader.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_fb_reader_pkg.sv
// Shared VGA definitions: frame geometry and the frame-buffer reader state type.
package vga_fb_reader_pkg;

  localparam int FB_WIDTH          = 640;
  localparam int FB_HEIGHT         = 480;
  localparam int FB_PIXELS_DEFAULT = FB_WIDTH * FB_HEIGHT;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } fb_state_e;

endpackage

// File: rtl/vga_fb_reader_sync_fifo.sv
// Synchronous first-word-fall-through FIFO: the head word is presented
// combinationally from the storage registers, and reads as zero when empty.
module sync_fifo
  import vga_fb_reader_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_flush,
  input  logic                   i_wr_en,
  input  logic [WIDTH-1:0]       i_wr_data,
  input  logic                   i_rd_en,
  output logic [WIDTH-1:0]       o_rd_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_wr_ok;
  logic             w_rd_ok;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_count   = r_count;
  // A write into a full FIFO is accepted only when the head leaves the same cycle.
  assign w_rd_ok   = i_rd_en && !o_empty;
  assign w_wr_ok   = i_wr_en && (!o_full || w_rd_ok);
  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties the FIFO in one cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_wr_ok) - (AW+1)'(w_rd_ok);
    end
  end

  // Storage write; data is not reset because empty masks the output.
  always_ff @(posedge i_clk) begin
    if (w_wr_ok) r_mem[r_wr_ptr] <= i_wr_data;
  end

endmodule

// File: rtl/vga_fb_reader.sv
// Frame-buffer reader: issues credit-limited SRAM reads for one frame and
// queues the returned words as a pixel stream for the VGA output stage.
module vga_fb_reader
  import vga_fb_reader_pkg::*;
#(
  parameter int ADDR_BITS  = 20,
  parameter int DATA_BITS  = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int FB_PIXELS  = FB_PIXELS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 frame_start,
  output logic                 sram_rd_req,
  output logic [ADDR_BITS-1:0] sram_addr,
  input  logic [DATA_BITS-1:0] sram_data,
  input  logic                 sram_data_valid,
  output logic                 pix_valid,
  output logic [DATA_BITS-1:0] pix_data,
  input  logic                 pix_ready,
  output logic                 underflow
);

  localparam int                   CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(FB_PIXELS - 1);
  localparam logic [CW:0]          DEPTH_L   = (CW+1)'(FIFO_DEPTH);

  fb_state_e            r_state;
  fb_state_e            w_state_nxt;
  logic [ADDR_BITS-1:0] r_addr;
  logic [CW-1:0]        r_inflight;
  logic [CW-1:0]        r_discard;
  logic                 r_underflow;
  logic [CW-1:0]        w_count;
  logic                 w_empty;
  logic                 w_full;
  logic [CW:0]          w_credit_sum;
  logic                 w_credit_ok;
  logic                 w_restart;
  logic                 w_go_idle;
  logic                 w_ret;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_issue;

  assign w_restart    = enable && frame_start;
  assign w_go_idle    = !enable;
  // Returns only count while a frame is being tracked; late ones in IDLE are ignored.
  assign w_ret        = sram_data_valid && (r_state != ST_IDLE) && (r_inflight != '0);
  assign w_push       = w_ret && (r_discard == '0);
  assign w_pop        = pix_valid && pix_ready;
  // Discarded reads stay in r_inflight, so they keep holding credit until they return.
  assign w_credit_sum = {1'b0, w_count} + {1'b0, r_inflight};
  assign w_credit_ok  = !w_full && (w_credit_sum < DEPTH_L);

  assign sram_rd_req  = w_issue;
  assign sram_addr    = r_addr;
  assign pix_valid    = !w_empty;
  assign underflow    = r_underflow;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .i_clk     (clk),
    .i_rst     (reset),
    .i_flush   (w_restart || w_go_idle),
    .i_wr_en   (w_push),
    .i_wr_data (sram_data),
    .i_rd_en   (w_pop),
    .o_rd_data (pix_data),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count)
  );

  // Next state and read issue; a restart cycle never issues so address 0 is next.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      ST_FETCH: begin
        if (!reset && !w_go_idle && !w_restart && w_credit_ok) begin
          w_issue = 1'b1;
          if (r_addr == LAST_ADDR) w_state_nxt = ST_DONE;
        end
      end
      default: ;
    endcase
    if (w_restart) w_state_nxt = ST_FETCH;
    if (w_go_idle) w_state_nxt = ST_IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Read address: restarts at 0 on each frame and parks on the last word.
  always_ff @(posedge clk) begin
    if (reset || w_restart)                  r_addr <= '0;
    else if (w_issue && r_addr != LAST_ADDR) r_addr <= r_addr + 1'b1;
  end

  // In-flight and discard counters; on restart every outstanding read is dropped.
  always_ff @(posedge clk) begin
    if (reset || w_go_idle) begin
      r_inflight <= '0;
      r_discard  <= '0;
    end else begin
      r_inflight <= r_inflight + CW'(w_issue) - CW'(w_ret);
      if (w_restart)                      r_discard <= r_inflight - CW'(w_ret);
      else if (w_ret && r_discard != '0)  r_discard <= r_discard - 1'b1;
    end
  end

  // Sticky underflow: consumer asked for a pixel the FIFO could not supply.
  always_ff @(posedge clk) begin
    if (reset)                                             r_underflow <= 1'b0;
    else if (r_state == ST_FETCH && pix_ready && !pix_valid) r_underflow <= 1'b1;
  end

endmodule

// File: tb/tb_vga_fb_reader.sv
// Self-checking bench for vga_fb_reader: latency-configurable SRAM model,
// queue-based reference model, directed table and randomized traffic.
module tb_vga_fb_reader;
  import vga_fb_reader_pkg::*;

  localparam int AB  = 20;
  localparam int DB  = 16;
  localparam int FD  = 16;
  localparam int FBP = 160;

  logic          clk = 1'b0;
  logic          reset, enable, frame_start, pix_ready;
  logic          sram_rd_req, sram_data_valid, pix_valid, underflow;
  logic [AB-1:0] sram_addr;
  logic [DB-1:0] sram_data, pix_data;

  always #5 clk = ~clk;

  vga_fb_reader #(.ADDR_BITS(AB), .DATA_BITS(DB), .FIFO_DEPTH(FD), .FB_PIXELS(FBP)) dut (
    .clk(clk), .reset(reset), .enable(enable), .frame_start(frame_start),
    .sram_rd_req(sram_rd_req), .sram_addr(sram_addr), .sram_data(sram_data),
    .sram_data_valid(sram_data_valid), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(pix_ready), .underflow(underflow)
  );

  typedef struct { int addr; int due; int epoch; int frame; } req_t;
  typedef struct { bit rst; bit en; bit fs; bit rdy; bit chk; bit e_rd; int e_addr; bit e_pv; int e_data; } vec_t;

  int          tests = 0, fails = 0, cyc = 0;
  req_t        pend[$];
  logic [15:0] mfifo[$];
  int          epoch = 0, frame_id = 0, m_state = 0, m_addr = 0, last_due = 0;
  bit          m_uf = 0, mvalid = 0;
  int          lat_min = 2, lat_max = 2;
  bit          s_rd, s_pv;
  int          s_addr, s_data;

  function automatic logic [15:0] word_at(int a);
    return 16'(a * 257 + 12345);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: drive inputs and SRAM response, sample, check model, advance model.
  task automatic step(input bit r, input bit e, input bit f, input bit p,
                      output bit o_rd, output int o_addr, output bit o_pv, output int o_data);
    req_t rq;
    bit   ret, exp_rd, pop;
    int   outst, lat, due;
    @(negedge clk);
    reset = r; enable = e; frame_start = f; pix_ready = p;
    ret = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      ret = 1'b1; rq = pend[0];
      sram_data_valid = 1'b1; sram_data = word_at(rq.addr);
    end else begin
      sram_data_valid = 1'b0; sram_data = 16'($urandom);
    end
    #1;
    o_rd = sram_rd_req; o_addr = int'(sram_addr); o_pv = pix_valid; o_data = int'(pix_data);
    outst = 0;
    foreach (pend[i]) if (pend[i].epoch == epoch) outst++;
    exp_rd = mvalid && m_state == 1 && e && !f && !r && (mfifo.size() + outst < FD);
    if (mvalid) begin
      chk("rd_req", o_rd, exp_rd);
      if (exp_rd) chk("addr", o_addr, m_addr);
      chk("pix_valid", o_pv, mfifo.size() > 0);
      if (mfifo.size() > 0) chk("pix_data", o_data, mfifo[0]);
      chk("underflow", underflow, m_uf);
    end
    if (ret) void'(pend.pop_front());
    if (o_rd) begin
      lat = $urandom_range(lat_max, lat_min);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend.push_back('{o_addr, due, epoch, frame_id});
    end
    pop = (mfifo.size() > 0) && p;
    if (m_state == 1 && p && mfifo.size() == 0) m_uf = 1'b1;
    if (r) begin
      m_state = 0; m_addr = 0; mfifo.delete(); epoch++; m_uf = 1'b0; mvalid = 1'b1;
    end else if (!e) begin
      m_state = 0; mfifo.delete(); epoch++;
    end else if (f) begin
      m_state = 1; m_addr = 0; mfifo.delete(); frame_id++;
    end else begin
      if (pop) void'(mfifo.pop_front());
      if (ret && m_state != 0 && rq.epoch == epoch && rq.frame == frame_id)
        mfifo.push_back(word_at(rq.addr));
      if (exp_rd) begin
        if (m_addr == FBP - 1) m_state = 2;
        else m_addr++;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    step(1, 1, 0, 0, s_rd, s_addr, s_pv, s_data);
    repeat (8) step(0, 1, 0, 0, s_rd, s_addr, s_pv, s_data);
  endtask

  vec_t tbl[26];

  initial begin
    int issues, pops, first_i, last_i, extra, found, got_a, got_p, cnt, quiet;
    bit p, e, f, r;
    reset = 1'b1; enable = 1'b0; frame_start = 1'b0; pix_ready = 1'b0;
    sram_data = '0; sram_data_valid = 1'b0;

    // Directed start-up table, latency 2, consumer stalled then popping twice.
    for (int i = 0; i < 26; i++) begin
      tbl[i] = '{rst: 1'b0, en: 1'b1, fs: 1'b0, rdy: 1'b0, chk: 1'b1,
                 e_rd: 1'b0, e_addr: 0, e_pv: 1'b0, e_data: 0};
      if (i >= 3 && i <= 18) begin tbl[i].e_rd = 1'b1; tbl[i].e_addr = i - 3; end
      if (i >= 6) begin tbl[i].e_pv = 1'b1; tbl[i].e_data = word_at(0); end
    end
    tbl[0].rst = 1'b1; tbl[0].chk = 1'b0;
    tbl[2].fs  = 1'b1;
    tbl[23].rdy = 1'b1;
    tbl[24].rdy = 1'b1; tbl[24].e_rd = 1'b1; tbl[24].e_addr = 16; tbl[24].e_data = word_at(1);
    tbl[25].e_rd = 1'b1; tbl[25].e_addr = 17; tbl[25].e_data = word_at(2);
    lat_min = 2; lat_max = 2;
    for (int i = 0; i < 26; i++) begin
      step(tbl[i].rst, tbl[i].en, tbl[i].fs, tbl[i].rdy, s_rd, s_addr, s_pv, s_data);
      if (tbl[i].chk) begin
        chk("tbl_rd_req", s_rd, tbl[i].e_rd);
        if (tbl[i].e_rd) chk("tbl_addr", s_addr, tbl[i].e_addr);
        chk("tbl_pix_valid", s_pv, tbl[i].e_pv);
        if (tbl[i].e_pv) chk("tbl_pix_data", s_data, tbl[i].e_data);
        if (i == 1) begin
          chk("rst_pix_data", s_data, 0);
          chk("rst_addr", s_addr, 0);
          chk("rst_underflow", underflow, 0);
        end
      end
    end

    // Full frame with a consumer that pops whenever data is present.
    do_reset();
    step(0, 1, 1, 0, s_rd, s_addr, s_pv, s_data);
    issues = 0; pops = 0; first_i = -1; last_i = -1;
    for (int k = 0; k < FBP + 40; k++) begin
      p = mfifo.size() > 0;
      step(0, 1, 0, p, s_rd, s_addr, s_pv, s_data);
      if (s_rd) begin issues++; if (first_i < 0) first_i = k; last_i = k; end
      if (s_pv && p) pops++;
    end
    extra = 0;
    for (int k = 0; k < 10; k++) begin
      step(0, 1, 0, 1, s_rd, s_addr, s_pv, s_data);
      if (s_rd) extra++;
    end
    chk("frame_issues", issues, FBP);
    chk("frame_throughput", last_i - first_i, FBP - 1);
    chk("frame_pops", pops, FBP);
    chk("done_no_reads", extra, 0);
    chk("frame_underflow", underflow, 0);

    // Mid-frame restart at address 100 with two reads outstanding.
    do_reset();
    step(0, 1, 1, 0, s_rd, s_addr, s_pv, s_data);
    found = 0;
    for (int k = 0; k < 400 && found == 0; k++) begin
      step(0, 1, 0, mfifo.size() > 0, s_rd, s_addr, s_pv, s_data);
      if (s_rd && s_addr == 99) found = 1;
    end
    chk("disc_reach_99", found, 1);
    step(0, 1, 1, mfifo.size() > 0, s_rd, s_addr, s_pv, s_data);
    chk("disc_addr_at_fs", s_addr, 100);
    chk("disc_no_rd_at_fs", s_rd, 0);
    got_a = 0; got_p = 0;
    for (int k = 0; k < 50 && (got_a == 0 || got_p == 0); k++) begin
      p = mfifo.size() > 0;
      step(0, 1, 0, p, s_rd, s_addr, s_pv, s_data);
      if (s_rd && got_a == 0) begin got_a = 1; chk("disc_restart_addr", s_addr, 0); end
      if (s_pv && p && got_p == 0) begin got_p = 1; chk("disc_first_pixel", s_data, word_at(0)); end
    end
    chk("disc_done", got_a + got_p, 2);

    // Underflow: pop request on an empty FIFO during FETCH is sticky until reset.
    do_reset();
    step(0, 1, 1, 0, s_rd, s_addr, s_pv, s_data);
    step(0, 1, 0, 1, s_rd, s_addr, s_pv, s_data);
    step(0, 1, 0, 0, s_rd, s_addr, s_pv, s_data);
    chk("uf_set", underflow, 1);
    for (int k = 0; k < 300; k++) step(0, 1, 0, ($urandom % 3) != 0, s_rd, s_addr, s_pv, s_data);
    chk("uf_sticky", underflow, 1);
    step(1, 1, 0, 0, s_rd, s_addr, s_pv, s_data);
    step(0, 1, 0, 0, s_rd, s_addr, s_pv, s_data);
    chk("uf_cleared", underflow, 0);

    // Enable drop mid-frame, then reset mid-FETCH; counters must start clean.
    repeat (6) step(0, 1, 0, 0, s_rd, s_addr, s_pv, s_data);
    step(0, 1, 1, 0, s_rd, s_addr, s_pv, s_data);
    repeat (25) step(0, 1, 0, ($urandom % 2) != 0, s_rd, s_addr, s_pv, s_data);
    step(0, 0, 0, 0, s_rd, s_addr, s_pv, s_data);
    step(0, 0, 0, 0, s_rd, s_addr, s_pv, s_data);
    chk("en_drop_rd", s_rd, 0);
    chk("en_drop_pv", s_pv, 0);
    repeat (8) step(0, 1, 0, 0, s_rd, s_addr, s_pv, s_data);
    step(0, 1, 1, 0, s_rd, s_addr, s_pv, s_data);
    repeat (20) step(0, 1, 0, ($urandom % 2) != 0, s_rd, s_addr, s_pv, s_data);
    step(1, 1, 0, 1, s_rd, s_addr, s_pv, s_data);
    step(0, 1, 0, 0, s_rd, s_addr, s_pv, s_data);
    chk("rst_fetch_rd", s_rd, 0);
    chk("rst_fetch_pv", s_pv, 0);
    chk("rst_fetch_addr", s_addr, 0);
    repeat (8) step(0, 1, 0, 0, s_rd, s_addr, s_pv, s_data);
    step(0, 1, 1, 0, s_rd, s_addr, s_pv, s_data);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      step(0, 1, 0, 0, s_rd, s_addr, s_pv, s_data);
      if (s_rd) cnt++;
    end
    chk("stall_read_count", cnt, FD);

    // Randomized traffic: variable latency, stalls, restarts, enable drops, resets.
    quiet = 0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 500 == 0) begin lat_min = 1; lat_max = $urandom_range(4, 1); end
      r = 1'b0; e = 1'b1; f = 1'b0;
      if (quiet > 0) begin
        quiet--;
        e = (quiet > 4) ? 1'b0 : 1'b1;
      end else if ($urandom % 1000 == 0) begin
        r = 1'b1; quiet = 8;
      end else if ($urandom % 400 == 0) begin
        e = 1'b0; quiet = 12;
      end else begin
        f = (n == 0) || ($urandom % 70 == 0);
      end
      p = ($urandom % 4) != 0;
      step(r, e, f, p, s_rd, s_addr, s_pv, s_data);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
